// File: rtl/uart_tx_pkg.sv
// Shared types, line levels and parity helper for the parametrised UART transmitter.
package uart_tx_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 9;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Zero-extended payload leaves the XOR unchanged, so one width fits all legal sizes.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts max(prescale,1) clocks and pulses bit_end_c on the last one.
module uart_tx_bit_timer #(
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   run,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   bit_end_c
);

    logic [PRESC_WIDTH-1:0] cnt;
    logic [PRESC_WIDTH-1:0] last;

    // Prescale is latched on start so mid-frame changes cannot stretch or shrink bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            last <= '0;
        end else if (start) begin
            cnt  <= '0;
            last <= (prescale == '0) ? '0 : prescale - PRESC_WIDTH'(1);
        end else if (!run || cnt == last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_WIDTH'(1);
        end
    end

    assign bit_end_c = run && (cnt == last);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits.
module uart_tx_param
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   Data_Valid,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   STOP2,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    output logic                   TX_OUT,
    output logic                   Busy
);

    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

    tx_state_e             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      bit_idx;
    logic                  stop_cnt;
    logic                  par;
    logic                  par_en_q;
    logic                  stop2_q;
    logic                  bit_end_c;
    logic                  last_stop_c;
    logic                  accept_c;

    assign last_stop_c = (state == STOP) && bit_end_c && (stop_cnt == stop2_q);
    assign accept_c    = Data_Valid && ((state == IDLE) || last_stop_c);

    uart_tx_bit_timer #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_bit_timer (
        .clk      (CLK),
        .rst_n    (RST),
        .start    (accept_c),
        .run      (Busy),
        .prescale (PRESCALE),
        .bit_end_c(bit_end_c)
    );

    // Frame sequencer; acceptance wins over the end-of-stop transition for back-to-back frames.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            TX_OUT   <= IDLE_LEVEL;
            Busy     <= 1'b0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
        end else if (accept_c) begin
            state    <= START;
            TX_OUT   <= START_LEVEL;
            Busy     <= 1'b1;
            shreg    <= P_DATA;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par      <= parity_bit(MAX_DATA_WIDTH'(P_DATA), PAR_TYP);
            par_en_q <= PAR_EN;
            stop2_q  <= STOP2;
        end else if (bit_end_c) begin
            case (state)
                START: begin
                    state  <= DATA;
                    TX_OUT <= shreg[0];
                end
                DATA: begin
                    if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        state  <= par_en_q ? PARITY : STOP;
                        TX_OUT <= par_en_q ? par : STOP_LEVEL;
                    end else begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        shreg   <= shreg >> 1;
                        TX_OUT  <= shreg[1];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= STOP_LEVEL;
                end
                STOP: begin
                    if (stop_cnt == stop2_q) begin
                        state  <= IDLE;
                        TX_OUT <= IDLE_LEVEL;
                        Busy   <= 1'b0;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param with DATA_WIDTH=8, PRESC_WIDTH=6.
module tb_uart_tx_param;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       Busy;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic exp_q[$];

    uart_tx_param #(
        .DATA_WIDTH (8),
        .PRESC_WIDTH(6)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .STOP2     (STOP2),
        .PRESCALE  (PRESCALE),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Appends the expected per-clock line levels of one frame to exp_q.
    task automatic build_exp(input logic [7:0] d, input logic pe, input logic pt,
                             input logic s2, input int p);
        logic bits[$];
        int   pp;
        pp = (p == 0) ? 1 : p;
        bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(d[j]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[j]) for (int r = 0; r < pp; r++) exp_q.push_back(bits[j]);
    endtask

    task automatic set_cfg(input logic [7:0] d, input logic pe, input logic pt,
                           input logic s2, input logic [5:0] p);
        P_DATA   = d;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = s2;
        PRESCALE = p;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) step();
        total_cnt++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            $display("FAIL reset_hold: tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        else pass_cnt++;
        RST = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            total_cnt++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0)
                $display("FAIL idle_c%0d: tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic(input string name, input logic [7:0] d, input logic [5:0] p);
        exp_q.delete();
        build_exp(d, 1'b0, 1'b0, 1'b0, int'(p));
        set_cfg(d, 1'b0, 1'b0, 1'b0, p);
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            total_cnt++;
            if (TX_OUT !== exp_q[i] || Busy !== 1'b1)
                $display("FAIL %s_c%0d: tx=%b busy=%b expected tx=%b busy=1",
                         name, i, TX_OUT, Busy, exp_q[i]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            $display("FAIL %s_end: tx=%b busy=%b expected tx=1 busy=0", name, TX_OUT, Busy);
        else pass_cnt++;
    endtask

    task automatic test_parity_prescale();
        exp_q.delete();
        build_exp(8'h03, 1'b1, 1'b1, 1'b1, 4);
        total_cnt++;
        if (exp_q.size() != 48)
            $display("FAIL par_len: model=%0d expected 48", exp_q.size());
        else pass_cnt++;
        set_cfg(8'h03, 1'b1, 1'b1, 1'b1, 6'd4);
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 2) set_cfg(8'hFF, 1'b0, 1'b0, 1'b0, 6'd1);
            total_cnt++;
            if (TX_OUT !== exp_q[i] || Busy !== 1'b1)
                $display("FAIL par_c%0d: tx=%b busy=%b expected tx=%b busy=1",
                         i, TX_OUT, Busy, exp_q[i]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            $display("FAIL par_end: tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        exp_q.delete();
        build_exp(8'h55, 1'b0, 1'b0, 1'b0, 1);
        build_exp(8'hAA, 1'b0, 1'b0, 1'b0, 1);
        set_cfg(8'h55, 1'b0, 1'b0, 1'b0, 6'd1);
        Data_Valid = 1'b1;
        step();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 0) P_DATA = 8'hAA;
            if (i == 10) Data_Valid = 1'b0;
            total_cnt++;
            if (TX_OUT !== exp_q[i] || Busy !== 1'b1)
                $display("FAIL b2b_c%0d: tx=%b busy=%b expected tx=%b busy=1",
                         i, TX_OUT, Busy, exp_q[i]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            $display("FAIL b2b_end: tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        else pass_cnt++;
    endtask

    task automatic test_ignore_busy();
        exp_q.delete();
        build_exp(8'h0F, 1'b0, 1'b0, 1'b0, 1);
        set_cfg(8'h0F, 1'b0, 1'b0, 1'b0, 6'd1);
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 3) begin
                P_DATA     = 8'hFF;
                Data_Valid = 1'b1;
            end
            if (i == 4) Data_Valid = 1'b0;
            total_cnt++;
            if (TX_OUT !== exp_q[i] || Busy !== 1'b1)
                $display("FAIL ign_c%0d: tx=%b busy=%b expected tx=%b busy=1",
                         i, TX_OUT, Busy, exp_q[i]);
            else pass_cnt++;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0)
                $display("FAIL ign_idle%0d: tx=%b busy=%b expected tx=1 busy=0", i, TX_OUT, Busy);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        set_cfg(8'hC3, 1'b0, 1'b0, 1'b0, 6'd1);
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        repeat (4) step();
        total_cnt++;
        if (TX_OUT !== 1'b0 || Busy !== 1'b1)
            $display("FAIL rst_pre: tx=%b busy=%b expected tx=0 busy=1", TX_OUT, Busy);
        else pass_cnt++;
        RST = 1'b0;
        #1;
        total_cnt++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            $display("FAIL rst_async: tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        else pass_cnt++;
        step();
        RST = 1'b1;
        repeat (3) step();
        total_cnt++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            $display("FAIL rst_noresume: tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        else pass_cnt++;
        exp_q.delete();
        build_exp(8'h81, 1'b1, 1'b0, 1'b0, 2);
        set_cfg(8'h81, 1'b1, 1'b0, 1'b0, 6'd2);
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            total_cnt++;
            if (TX_OUT !== exp_q[i] || Busy !== 1'b1)
                $display("FAIL rst_new_c%0d: tx=%b busy=%b expected tx=%b busy=1",
                         i, TX_OUT, Busy, exp_q[i]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0)
            $display("FAIL rst_new_end: tx=%b busy=%b expected tx=1 busy=0", TX_OUT, Busy);
        else pass_cnt++;
    endtask

    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b0;
        set_cfg(8'h00, 1'b0, 1'b0, 1'b0, 6'd1);
        test_reset();
        test_basic("basic", 8'hA5, 6'd1);
        test_basic("presc0", 8'h5A, 6'd0);
        test_basic("presc3", 8'h96, 6'd3);
        test_parity_prescale();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
